module_keypad_scan: RTL and testbench

Front end for the operand-sequencing FSM. It scans a 4x4 active-low matrix keypad, debounces the keys and registers a 4-bit key code. It then issues exactly one single-cycle rdy strobe per physical key press. That strobe is the rdy input consumed by the load_a/load_b/load_s sequencer, and key_o is the data that the sequencer's load enables capture.

---
 rtl/module_keypad_scan_if.sv | 27 ++
 rtl/module_keypad_scan.sv | 151 +++++++++++++++
 tb/tb_module_keypad_scan.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/module_keypad_scan_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the key code
// handshake toward the operand sequencer.
interface module_keypad_scan_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_o;
  logic       rdy;
  logic       busy;

  // Scanner side
  modport master (
    input  row_i,
    output col_o,
    output key_o,
    output rdy,
    output busy
  );

  // Keypad / sequencer side
  modport slave (
    output row_i,
    input  col_o,
    input  key_o,
    input  rdy,
    input  busy
  );
endinterface

// File: rtl/module_keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and a
// single-cycle rdy strobe per accepted press.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_SCAN     | rotate column drive, look for a low row at window end
// ST_DEBOUNCE | column frozen, require the detected row low DEBOUNCE cycles
// ST_PRESS    | one cycle: key_o updated, rdy high
// ST_RELEASE  | column frozen, require all rows high DEBOUNCE cycles
module module_keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  module_keypad_scan_if.master bus
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESS    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    key_q, key_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic [3:0]    row_meta_q;
  logic [3:0]    row_s_q;
  logic [1:0]    det_row;

  // Two-flop synchronizer for the asynchronous row inputs; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= bus.row_i;
      row_s_q    <= row_meta_q;
    end
  end

  // Fixed-priority row encoder: the lowest low row wins.
  always_comb begin
    det_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) det_row = 2'(i);
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    key_d     = key_q;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_s_q != 4'hF) begin
            row_idx_d = det_row;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!row_s_q[row_idx_q]) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_PRESS;
            key_d   = {row_idx_q, col_idx_q};
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Bounce: give up and resume scanning past this column.
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
          cnt_d     = '0;
        end
      end
      ST_PRESS: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end
      ST_RELEASE: begin
        if (row_s_q == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
    // Flags are registered from the next state so they align with it.
    rdy_d  = (state_d == ST_PRESS);
    busy_d = (state_d != ST_SCAN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_SCAN;
      cnt_q     <= '0;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      key_q     <= 4'h0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      key_q     <= key_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.col_o = ~(4'b0001 << col_idx_q);
  assign bus.key_o = key_q;
  assign bus.rdy   = rdy_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Bench for module_keypad_scan with SCAN_DIV=4, DEBOUNCE=8. A keypad matrix
// model drives the rows from the column drive; expected key codes go into a
// scoreboard queue and a monitor pops one on every rdy strobe.
module tb_module_keypad_scan;
  logic        clk;
  logic        rst;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down
  logic [3:0]  rows;
  int          nchk, npass, cyc, rdy_seen, busy_rise_cyc;
  logic        rdy_prev, busy_prev;
  logic [3:0]  exp_q[$];

  module_keypad_scan_if kif();

  module_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_o[c]) rows[r] = 1'b0;
  end
  assign kif.row_i = rows;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on each rdy, checks pulse width and latency.
  always @(negedge clk) begin
    if (kif.busy && !busy_prev) busy_rise_cyc = cyc;
    if (rdy_prev) check("rdy_width", {31'd0, kif.rdy}, 32'd0);
    if (kif.rdy) begin
      rdy_seen++;
      if (exp_q.size() == 0) begin
        check("rdy_unexpected", 32'd1, 32'd0);
      end else begin
        check("key_o", {28'd0, kif.key_o}, {28'd0, exp_q.pop_front()});
        check("rdy_latency", cyc - busy_rise_cyc, 32'd8);
        check("busy_at_rdy", {31'd0, kif.busy}, 32'd1);
      end
    end
    rdy_prev  = kif.rdy;
    busy_prev = kif.busy;
  end

  function automatic logic [3:0] col_code(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Wait for the start of a window on column idx.
  task automatic wait_col(input int idx);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (kif.col_o != col_code(idx)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (kif.col_o == col_code(idx)) begin ok = 1'b1; break; end
      end
    end
    check("wait_col_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_busy(input logic val, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (kif.busy == val) begin ok = 1'b1; break; end
    end
    check("wait_busy_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rdy(input int budget);
    int start;
    logic ok;
    start = rdy_seen;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rdy_seen != start) begin ok = 1'b1; break; end
    end
    check("wait_rdy_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},  {28'd0, kif.col_o}, 32'hE);
    check({tag, "_key"},  {28'd0, kif.key_o}, 32'h0);
    check({tag, "_rdy"},  {31'd0, kif.rdy},   32'd0);
    check({tag, "_busy"}, {31'd0, kif.busy},  32'd0);
  endtask

  initial begin
    logic saw_busy;
    nchk = 0; npass = 0; cyc = 0; rdy_seen = 0; busy_rise_cyc = 0;
    rdy_prev = 1'b0; busy_prev = 1'b0;
    pressed = 16'h0;
    rst = 1'b0;

    // 1: reset values and column rotation
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1 check("scan_col", {28'd0, kif.col_o}, {28'd0, col_code((n / 4) % 4)});
      @(negedge clk);
    end

    // 2: key row1/col2, one rdy, clean release
    wait_col(2);
    pressed[1*4+2] = 1'b1;
    exp_q.push_back(4'b0110);
    wait_busy(1'b1, 10);
    wait_rdy(20);
    repeat (3) @(negedge clk);
    check("frozen_col", {28'd0, kif.col_o}, 32'hB);
    pressed = 16'h0;
    repeat (9) @(negedge clk);
    check("release_busy_hold", {31'd0, kif.busy}, 32'd1);
    @(negedge clk);
    check("release_busy_drop", {31'd0, kif.busy}, 32'd0);
    check("release_next_col", {28'd0, kif.col_o}, 32'h7);

    // 3: bounce of 5 cycles during column 2 -> abort, no rdy
    wait_col(2);
    pressed[1*4+2] = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (kif.busy) saw_busy = 1'b1;
    end
    pressed = 16'h0;
    check("bounce_detected", {31'd0, saw_busy}, 32'd1);
    wait_busy(1'b0, 10);
    check("bounce_next_col", {28'd0, kif.col_o}, 32'h7);
    check("bounce_key_kept", {28'd0, kif.key_o}, 32'h6);

    // 4: long hold of row3/col0, release with a glitch
    wait_col(0);
    pressed[3*4+0] = 1'b1;
    exp_q.push_back(4'b1100);
    repeat (100) @(negedge clk);
    check("hold_busy", {31'd0, kif.busy}, 32'd1);
    pressed = 16'h0;
    repeat (4) @(negedge clk);
    pressed[3*4+0] = 1'b1;
    @(negedge clk);
    pressed = 16'h0;
    repeat (9) @(negedge clk);
    check("glitch_busy_hold", {31'd0, kif.busy}, 32'd1);
    @(negedge clk);
    check("glitch_busy_drop", {31'd0, kif.busy}, 32'd0);
    check("glitch_next_col", {28'd0, kif.col_o}, 32'hD);

    // 5: rows 0 and 2 on column 1 -> row 0 wins
    wait_col(1);
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    exp_q.push_back(4'b0001);
    wait_rdy(30);
    pressed = 16'h0;
    wait_busy(1'b0, 20);

    // 6: reset during DEBOUNCE, then during RELEASE, key held throughout
    wait_col(3);
    pressed[2*4+3] = 1'b1;
    wait_busy(1'b1, 10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_vals("rst_debounce");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'b1011);
    wait_rdy(60);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_vals("rst_release");
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(4'b1011);
    wait_rdy(60);
    pressed = 16'h0;
    wait_busy(1'b0, 20);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
